color_seq_engine: RTL
=====================

// Module: color_seq_engine
// PURPOSE
//  Round engine for the colour-memory game, directly downstream of the lfsr generator.
//  - Each round, takes one 2-bit colour from the lfsr output and appends it to a stored sequence.
//  - Plays the whole sequence back to the display with timed on/off phases.
//  - Checks player guesses (one colour per guess) against the stored sequence.
//  - Reports win/fail and the current level to the top level (LEDR/HEX).
// PARAMETERS
//  MAX_LEN    16  sequence length that wins the game (2..32)
//  TICKS_ON   25_000_000  clk cycles each colour is shown during playback (>=1)
//  TICKS_OFF  12_500_000  clk cycles of blank gap after each shown colour (>=1)
// PORTS
//  clk          in   1  system clock (CLOCK_50)
//  reset        in   1  synchronous, active-high
//  rand_in      in   8  lfsr output; only [1:0] is consumed, sampled in APPEND
//  start        in   1  one-cycle pulse; begins a new game
//  guess_valid  in   1  one-cycle pulse; guess_color is valid this cycle
//  guess_color  in   2  player colour: 0 red, 1 blue, 2 yellow, 3 green
//  show_valid   out  1  high while a colour is being displayed
//  show_color   out  2  colour being displayed; 0 when show_valid=0
//  expect_input out  1  high in WAIT_IN (player may guess)
//  result_ok    out  1  high in WIN, held until start
//  result_fail  out  1  high in FAIL, held until start
//  level        out  $clog2(MAX_LEN+1)  current sequence length
// BEHAVIOUR
//  Interface: reset reset, synchronous, active-high; clock clk.
//  - Reset: state=IDLE, len=0, idx=0, timer=0.
//  - Reset values of all outputs are 0. Sequence memory contents are don't-care.
//  - Reset mid-operation aborts the round with the same result.
//  FSM (registered outputs decoded from state):
//  - IDLE:     start -> APPEND with len cleared to 0.
//  - WIN/FAIL: start -> APPEND with len cleared to 0.
//  - APPEND (1 cycle): mem[len] <= rand_in[1:0]; len <= len+1; idx <= 0 -> SHOW_ON.
//  - SHOW_ON: show_valid=1, show_color=mem[idx], held exactly TICKS_ON cycles -> SHOW_OFF.
//  - SHOW_OFF: outputs blank for exactly TICKS_OFF cycles.
//      - idx==len-1: -> WAIT_IN with idx=0.
//      - otherwise:  idx++ -> SHOW_ON.
//  - WAIT_IN: expect_input=1. On guess_valid, compare guess_color with mem[idx]:
//      - mismatch -> FAIL.
//      - match, idx<len-1 -> idx++, stay in WAIT_IN.
//      - match, idx==len-1, len==MAX_LEN -> WIN.
//      - match, idx==len-1, len<MAX_LEN -> APPEND (next round).
//  - Ignored inputs:
//      - start is ignored in APPEND, SHOW_ON, SHOW_OFF and WAIT_IN.
//      - guess_valid is ignored outside WAIT_IN.
//      - If start and guess_valid arrive in the same cycle, the rule for the current state applies.
//  - level equals len at all times; it is updated the cycle after APPEND.
//  - Latency: from start to first show_valid is 2 cycles (IDLE->APPEND->SHOW_ON).
//  - Playback of length L takes L*(TICKS_ON+TICKS_OFF) cycles.
//  - Timer is a down-counter reloaded on each phase entry; width is $clog2(max(TICKS_ON,TICKS_OFF)+1).
//  - idx and len never wrap: len saturates at MAX_LEN via the WIN transition.
// CONFIGURATION
//  Macro COLOR_SEQ_NO_REPEAT_EN:
//  - Defined: in APPEND, if len>0 and rand_in[1:0]==mem[len-1], store (rand_in[1:0]+1) mod 4 instead.
//    No two adjacent sequence entries are equal.
//  - Undefined: rand_in[1:0] is stored unmodified; repeats are allowed.
// STRUCTURE
//  Shared package game_pkg:
//  - colour codes COL_RED=2'd0, COL_BLUE=2'd1, COL_YELLOW=2'd2, COL_GREEN=2'd3;
//  - state encoding IDLE, APPEND, SHOW_ON, SHOW_OFF, WAIT_IN, WIN, FAIL.
//  Sub-module phase_timer: load value, load strobe, done pulse.
//  Sequence store: MAX_LEN x 2 register array in this module.
// TESTING (bench: MAX_LEN=4, TICKS_ON=3, TICKS_OFF=2)
//  1. Reset held, then start; rand_in=8'h02.
//     -> show_valid high 3 cycles with show_color=2, then low 2 cycles.
//     -> expect_input=1 and level=1.
//  2. Round 1 stored 2; guess 2; rand_in=8'h01 at APPEND.
//     -> level=2; playback shows 2 then 1.
//     -> guesses 2,1 -> next APPEND.
//  3. In WAIT_IN with mem[0]=2, guess 3.
//     -> result_fail=1, expect_input=0; held until start.
//     -> start -> level=1.
//  4. Complete 4 correct rounds.
//     -> result_ok=1, level=4.
//     -> further guess_valid pulses change nothing.
//  5. Assert reset during SHOW_ON of round 3.
//     -> next cycle all outputs 0, level=0.
//     -> start and guess_valid pulses in SHOW_ON are ignored.
//  6. With COLOR_SEQ_NO_REPEAT_EN: rand_in[1:0]=1 on two consecutive rounds.
//     -> stored entries are 1, 2.
//     -> without the macro they are 1, 1.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the colour-memory game.
//   - Colour codes as presented to the player and the display.
//   - State encoding of the round engine (color_seq_engine).
//   - col_next(): the colour that follows a given colour, wrapping modulo 4.
package game_pkg;

  localparam logic [1:0] COL_RED    = 2'd0;
  localparam logic [1:0] COL_BLUE   = 2'd1;
  localparam logic [1:0] COL_YELLOW = 2'd2;
  localparam logic [1:0] COL_GREEN  = 2'd3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    APPEND   = 3'd1,
    SHOW_ON  = 3'd2,
    SHOW_OFF = 3'd3,
    WAIT_IN  = 3'd4,
    WIN      = 3'd5,
    FAIL     = 3'd6
  } state_t;

  // Two-bit addition wraps naturally, giving (c+1) mod 4.
  function automatic logic [1:0] col_next(input logic [1:0] c);
    return c + 2'd1;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Down-counter used to time the playback phases.
//   clk        in   system clock
//   reset      in   synchronous, active-high; clears the count to 0
//   load       in   strobe; count takes load_value on the next edge
//   load_value in   WIDTH  value to load (phase length minus one)
//   done       out  high while the count is zero (last cycle of a phase)
// A phase loaded with N-1 therefore lasts exactly N cycles.
module phase_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - WIDTH'(1);
    end
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/color_seq_engine.sv
// Round engine of the colour-memory game.
// Each round appends one colour (from the lfsr) to a stored sequence, plays the
// whole sequence back with timed on/off phases, then checks the player's
// guesses against it. Reaching MAX_LEN correct entries wins the game.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high
//   rand_in      in   8  lfsr output, only [1:0] is used (sampled in APPEND)
//   start        in   one-cycle pulse, begins a new game (IDLE/WIN/FAIL only)
//   guess_valid  in   one-cycle pulse, guess_color valid (WAIT_IN only)
//   guess_color  in   2  player colour
//   show_valid   out  colour being displayed
//   show_color   out  2  displayed colour, 0 when show_valid is low
//   expect_input out  player may guess
//   result_ok    out  game won, held until start
//   result_fail  out  game lost, held until start
//   level        out  current sequence length
//
// Build option: define COLOR_SEQ_NO_REPEAT_EN to forbid two equal adjacent
// entries (a repeated colour is bumped to the next colour code on append).
module color_seq_engine
  import game_pkg::*;
#(
  parameter int MAX_LEN   = 16,
  parameter int TICKS_ON  = 25_000_000,
  parameter int TICKS_OFF = 12_500_000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   rand_in,
  input  logic                         start,
  input  logic                         guess_valid,
  input  logic [1:0]                   guess_color,
  output logic                         show_valid,
  output logic [1:0]                   show_color,
  output logic                         expect_input,
  output logic                         result_ok,
  output logic                         result_fail,
  output logic [$clog2(MAX_LEN+1)-1:0] level
);

  localparam int LEN_W    = $clog2(MAX_LEN + 1);
  localparam int IDX_W    = $clog2(MAX_LEN);
  localparam int TICK_MAX = (TICKS_ON > TICKS_OFF) ? TICKS_ON : TICKS_OFF;
  localparam int TIMER_W  = $clog2(TICK_MAX + 1);

  localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(TICKS_ON - 1);
  localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(TICKS_OFF - 1);
  localparam logic [LEN_W-1:0]   LEN_MAX  = LEN_W'(MAX_LEN);

  state_t             state_reg, state_next;
  logic [LEN_W-1:0]   len_reg, len_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;

  logic               timer_load;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_done;

  logic [1:0]         mem [MAX_LEN];
  logic [MAX_LEN-1:0] wr_en;
  logic [IDX_W-1:0]   wr_addr;
  logic [1:0]         append_color;
  logic [1:0]         mem_at_idx;
  logic [LEN_W-1:0]   last_idx;
  logic               idx_is_last;

  // Upper lfsr bits are intentionally not consumed.
  logic               unused_rand;
  assign unused_rand = ^rand_in[7:2];

  phase_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timer_load),
    .load_value(timer_value),
    .done      (timer_done)
  );

  // len never reaches MAX_LEN while in APPEND (WIN is taken instead), so the
  // truncated write address is always in range.
  assign wr_addr     = len_reg[IDX_W-1:0];
  assign mem_at_idx  = mem[idx_reg];
  assign last_idx    = len_reg - LEN_W'(1);
  assign idx_is_last = (LEN_W'(idx_reg) == last_idx);

`ifdef COLOR_SEQ_NO_REPEAT_EN
  logic [IDX_W-1:0] prev_addr;
  assign prev_addr = IDX_W'(last_idx);
  always_comb begin
    append_color = rand_in[1:0];
    if ((len_reg != '0) && (rand_in[1:0] == mem[prev_addr])) begin
      append_color = col_next(rand_in[1:0]);
    end
  end
`else
  assign append_color = rand_in[1:0];
`endif

  // Per-entry write enables for the sequence store.
  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_wr_en
      assign wr_en[gi] = (state_reg == APPEND) && (wr_addr == IDX_W'(gi));
    end
  endgenerate

  // Sequence store has no reset: entries beyond len are never read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_LEN; i++) begin
      if (wr_en[i]) begin
        mem[i] <= append_color;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      len_reg   <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    len_next    = len_reg;
    idx_next    = idx_reg;
    timer_load  = 1'b0;
    timer_value = ON_LOAD;

    case (state_reg)
      IDLE, WIN, FAIL: begin
        if (start) begin
          state_next = APPEND;
          len_next   = '0;
          idx_next   = '0;
        end
      end

      APPEND: begin
        len_next    = len_reg + LEN_W'(1);
        idx_next    = '0;
        state_next  = SHOW_ON;
        timer_load  = 1'b1;
        timer_value = ON_LOAD;
      end

      SHOW_ON: begin
        if (timer_done) begin
          state_next  = SHOW_OFF;
          timer_load  = 1'b1;
          timer_value = OFF_LOAD;
        end
      end

      SHOW_OFF: begin
        if (timer_done) begin
          if (idx_is_last) begin
            state_next = WAIT_IN;
            idx_next   = '0;
          end else begin
            state_next  = SHOW_ON;
            idx_next    = idx_reg + IDX_W'(1);
            timer_load  = 1'b1;
            timer_value = ON_LOAD;
          end
        end
      end

      WAIT_IN: begin
        if (guess_valid) begin
          if (guess_color != mem_at_idx) begin
            state_next = FAIL;
          end else if (!idx_is_last) begin
            idx_next = idx_reg + IDX_W'(1);
          end else if (len_reg == LEN_MAX) begin
            state_next = WIN;
          end else begin
            state_next = APPEND;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are decoded purely from registered state.
  always_comb begin
    show_valid   = (state_reg == SHOW_ON);
    show_color   = 2'd0;
    expect_input = (state_reg == WAIT_IN);
    result_ok    = (state_reg == WIN);
    result_fail  = (state_reg == FAIL);
    if (state_reg == SHOW_ON) begin
      show_color = mem_at_idx;
    end
  end

  assign level = len_reg;

endmodule
